tdc_fifo_reader: RTL
====================

TDC_FIFO_READER -- requirements
Module: tdc_fifo_reader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hAA, first byte of every frame.
REQ-002 SHALL have parameter IDLE_GAP, default 16'd0, minimum clk cycles between frame_done and the next FIFO pop.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on posedge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port fifo_empty  in  1  measurement FIFO empty flag.
REQ-006 SHALL have port fifo_dout  in  32  FIFO word {calib_diff[31:16], time1[15:0]}, valid one cycle after the fifo_rd_en cycle.
REQ-007 SHALL have port fifo_rd_en  out  1  one-cycle pop strobe.
REQ-008 SHALL have port tx_busy  in  1  byte transmitter busy.
REQ-009 SHALL have port tx_data  out  8  byte to transmit.
REQ-010 SHALL have port tx_new_data  out  1  one-cycle strobe qualifying tx_data.
REQ-011 SHALL have port pause  in  1  hold off new frames.
REQ-012 SHALL have port exit  in  1  abort current frame.
REQ-013 SHALL have port frame_done  out  1  one-cycle pulse after the last byte of a frame is accepted.
REQ-014 SHALL have port seq_count  out  8  sequence number of the next frame.

Function
REQ-015 Frame SHALL be 7 bytes in order: SYNC_BYTE, SEQ, D[31:24], D[23:16], D[15:8], D[7:0], CHK.
REQ-016 CHK SHALL be the bitwise XOR of SEQ and the four data bytes; SYNC_BYTE excluded.
REQ-017 States SHALL be IDLE, GAP, POP, LATCH, SEND, DRAIN.
REQ-018 IDLE: if fifo_empty=0, pause=0 and exit=0 -> POP; otherwise stay.
REQ-019 POP: fifo_rd_en=1 for exactly this one cycle -> LATCH.
REQ-020 LATCH: capture fifo_dout and seq_count, compute CHK, byte index=0 -> SEND.
REQ-021 SEND: when tx_busy=0 and tx_new_data was 0 in the previous cycle, drive tx_data=byte[index] with tx_new_data=1 for one cycle; after index 6 -> DRAIN, otherwise index+1.
REQ-022 tx_data SHALL hold its value until the next strobe.
REQ-023 tx_new_data SHALL never be high on two consecutive cycles.
REQ-024 DRAIN: when tx_busy=0 and tx_new_data=0, pulse frame_done, seq_count+1 (wraps 255->0), gap counter=0 -> GAP.
REQ-025 GAP: count up; when count>=IDLE_GAP -> IDLE; IDLE_GAP=0 gives one GAP cycle.
REQ-026 Latency with tx_busy=0 and fifo_empty=0: fifo_rd_en at T+1, word latched at T+2, SYNC strobe at T+3, where T is the IDLE cycle.
REQ-027 pause=1 SHALL only block the IDLE->POP transition; a frame in progress completes fully.
REQ-028 exit=1 in any state SHALL force IDLE next cycle.
REQ-029 On exit: tx_new_data=0 and fifo_rd_en=0 from the next cycle, frame_done not pulsed, seq_count unchanged; an already-popped word is discarded.
REQ-030 exit SHALL take priority over pause; pause and exit together leave the block in IDLE.
REQ-031 fifo_empty SHALL be sampled only in IDLE; the FIFO is never popped when empty.
REQ-032 At most one word SHALL be outstanding at a time.
REQ-033 A tx_busy rise between strobes SHALL stall SEND at the current index with no byte lost or duplicated.

Reset
REQ-034 rst=0 at a posedge SHALL set: state=IDLE, fifo_rd_en=0, tx_new_data=0, tx_data=8'h00, frame_done=0, seq_count=0, index=0, gap counter=0, latched word=0.
REQ-035 Reset mid-frame SHALL behave as exit and also clear seq_count; no partial strobe after the reset cycle.
REQ-036 The first cycle with rst=1 SHALL evaluate IDLE transitions normally.

Verification
REQ-037 Single word: FIFO holds 32'h03E8_05D0, tx_busy=0 -> one fifo_rd_en; bytes AA,00,03,E8,05,D0,CHK=3E; frame_done pulse; seq_count=1.
REQ-038 Back-to-back: 3 words, IDLE_GAP=4 -> three frames with SEQ 00,01,02; each fifo_rd_en at least 5 cycles after the previous frame_done.
REQ-039 Backpressure: tx_busy high 10 cycles after every strobe -> exactly 7 strobes per frame, never consecutive, byte order intact.
REQ-040 Pause/exit: pause=1 with FIFO non-empty -> no fifo_rd_en. Pause raised during byte 3 -> frame completes. Exit during byte 3 -> no further strobes, no frame_done, seq_count unchanged.
REQ-041 Wrap and reset: 256 frames -> seq_count returns to 00 and the 257th frame carries SEQ 00. rst=0 mid-frame -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/tdc_fifo_reader.sv
// TDC FIFO reader: pops one measurement word at a time and serialises it
// as a 7-byte frame (sync, sequence, four data bytes, XOR checksum).
module tdc_fifo_reader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hAA,
  parameter logic [15:0] IDLE_GAP  = 16'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  output logic        fifo_rd_en,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_new_data,
  input  logic        pause,
  input  logic        exit,
  output logic        frame_done,
  output logic [7:0]  seq_count
);

  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned GAP_W    = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_POP, S_LATCH, S_SEND, S_DRAIN
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [BYTE_W-1:0]   seq_lat_q, seq_lat_d;
  logic [BYTE_W-1:0]   chk_q, chk_d;
  logic [BYTE_W-1:0]   seq_q, seq_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_nd_q, tx_nd_d;
  logic                rd_en_q, rd_en_d;
  logic                done_q, done_d;
  logic                issue_c;
  logic [BYTE_W-1:0]   byte_c;

  // A strobe is decided one cycle ahead so that it appears registered; the
  // sync byte is constant, so it can already be issued from LATCH.
  assign issue_c = !exit && !tx_busy && !tx_nd_q &&
                   ((state_q == S_LATCH) || (state_q == S_SEND));

  // Frame byte selected by the current index.
  always_comb begin
    byte_c = SYNC_BYTE;
    unique case (idx_q)
      IDX_W'(0): byte_c = SYNC_BYTE;
      IDX_W'(1): byte_c = seq_lat_q;
      IDX_W'(2): byte_c = word_q[31:24];
      IDX_W'(3): byte_c = word_q[23:16];
      IDX_W'(4): byte_c = word_q[15:8];
      IDX_W'(5): byte_c = word_q[7:0];
      IDX_W'(6): byte_c = chk_q;
      default:   byte_c = SYNC_BYTE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; exit overrides everything.
  always_comb begin
    state_d = state_q;
    if (exit) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (!fifo_empty && !pause) state_d = S_POP;
        S_POP:   state_d = S_LATCH;
        S_LATCH: state_d = S_SEND;
        S_SEND:  if (issue_c && (idx_q == LAST_IDX)) state_d = S_DRAIN;
        S_DRAIN: if (!tx_busy && !tx_nd_q) state_d = S_GAP;
        S_GAP:   if (gap_q >= IDLE_GAP) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath next values; strobes default low every cycle.
  always_comb begin
    idx_d     = idx_q;
    gap_d     = gap_q;
    word_d    = word_q;
    seq_lat_d = seq_lat_q;
    chk_d     = chk_q;
    seq_d     = seq_q;
    tx_data_d = tx_data_q;
    tx_nd_d   = 1'b0;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;
    if (exit) begin
      idx_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: rd_en_d = !fifo_empty && !pause;
        S_POP:  idx_d = '0;
        S_LATCH: begin
          word_d    = fifo_dout;
          seq_lat_d = seq_q;
          chk_d     = seq_q ^ fifo_dout[31:24] ^ fifo_dout[23:16] ^
                      fifo_dout[15:8] ^ fifo_dout[7:0];
        end
        S_DRAIN: begin
          if (!tx_busy && !tx_nd_q) begin
            done_d = 1'b1;
            seq_d  = seq_q + BYTE_W'(1);
            gap_d  = '0;
          end
        end
        S_GAP: if (gap_q < IDLE_GAP) gap_d = gap_q + GAP_W'(1);
        default: ;
      endcase
      if (issue_c) begin
        tx_nd_d   = 1'b1;
        tx_data_d = byte_c;
        idx_d     = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q     <= '0;
      gap_q     <= '0;
      word_q    <= '0;
      seq_lat_q <= '0;
      chk_q     <= '0;
      seq_q     <= '0;
      tx_data_q <= '0;
      tx_nd_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      word_q    <= word_d;
      seq_lat_q <= seq_lat_d;
      chk_q     <= chk_d;
      seq_q     <= seq_d;
      tx_data_q <= tx_data_d;
      tx_nd_q   <= tx_nd_d;
      rd_en_q   <= rd_en_d;
      done_q    <= done_d;
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign tx_data     = tx_data_q;
  assign tx_new_data = tx_nd_q;
  assign frame_done  = done_q;
  assign seq_count   = seq_q;

endmodule
